snoop_bus_arbiter: RTL and testbench
====================================

# snoop_bus_arbiter

Arbiter and sequencer for the shared snooping bus between the two cache CPUs and the single data memory. Accepts one coherence transaction at a time from either CPU with round-robin fairness, broadcasts it to the other CPU's snoop port, and drives the memory port for write-backs and misses. For misses it resolves the data from a snooper-supplied cache line when one is offered, and from memory otherwise. It replaces the ad-hoc fixed-priority sequencing in the bus top level.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles from memory address to valid `memory_data_out`; legal range 1..7.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_cpu1, req_cpu2  in  1  transaction request, held high until `reply_valid` for that CPU
- msg_cpu1, msg_cpu2  in  13  bus message from the CPU: request when `req` is high, snoop response otherwise
- gnt_cpu1, gnt_cpu2  out  1  one-cycle grant pulse
- snoop_valid_cpu1, snoop_valid_cpu2  out  1  snoop broadcast valid, asserted only to the non-owner CPU
- snoop_msg  out  13  latched owner message
- reply_valid_cpu1, reply_valid_cpu2  out  1  one-cycle completion pulse
- reply_msg  out  13  completion message to the owner
- memory_write  out  1  memory write enable
- memory_address  out  3  memory address
- memory_data_in  out  4  memory write data
- memory_data_out  in  4  memory read data
- busy  out  1  high in every state except IDLE

## Operation
- Message fields:
  - [12] WB
  - [11] SUPPLY
  - [10] INV
  - [9] RMISS
  - [8] WMISS
  - [7] reserved, driven 0
  - [6:4] address
  - [3:0] data
- A request carries exactly one of WB, INV, RMISS or WMISS. SUPPLY is valid only on a snooper's message.
- FSM states: IDLE → SNOOP → MEM → RESP → IDLE.
  - IDLE: sample both `req`. On any request, pick the owner and latch its message and owner ID, then go to SNOOP.
  - SNOOP (1 cycle):
    - `gnt` pulses to the owner; `snoop_valid` pulses to the other CPU; `memory_address` = latched address.
    - WB: `memory_write`=1 and `memory_data_in` = latched data, then go to RESP.
    - INV: go to RESP.
    - RMISS/WMISS: go to MEM with a 3-bit latency counter loaded to MEM_LATENCY.
  - MEM: decrement the counter each cycle; go to RESP when it reaches 1.
  - RESP (1 cycle):
    - `reply_valid` pulses to the owner.
    - `reply_msg` = latched kind bits plus address.
    - Data: WB echoes the written data; INV gives 0; a miss gives the supplied data if captured, else `memory_data_out`.
    - Flip the priority pointer to the non-owner, then return to IDLE.
- Supply capture: during SNOOP and MEM, if the snooper's `msg` has SUPPLY=1 and its address equals the latched address, capture its data once. The first capture wins; later captures are ignored.
- Round-robin:
  - Pointer resets to favour cpu1.
  - Both requesting in IDLE → the pointer's CPU wins.
  - A single requester wins regardless of the pointer.
- `req` is not sampled outside IDLE. A `req` dropped after the grant does not abort the transaction. A `req` still high in the IDLE cycle after the reply counts as a new request.
- Unrecognised or zero kind bits: treat as INV (reply only, no memory access).

## Timing
- Reset: all outputs 0, state IDLE, pointer = cpu1, capture flag cleared. A reset asserted mid-transaction abandons it with no reply and no further memory write.
- All outputs are registered or decoded from registered state; no combinational path from `req`/`msg` to outputs.
- Latency, with request sampled in cycle T:
  - SNOOP at T+1.
  - WB/INV: reply at T+2.
  - RMISS/WMISS: reply at T+2+MEM_LATENCY.
- Back-to-back: the earliest next grant is 2 cycles after the reply (one IDLE cycle to sample `req`, then SNOOP).
- `memory_address` holds the latched address from SNOOP through RESP. `memory_write` is high only during the WB SNOOP cycle.

## Structure
- Shared package `bus_pkg`:
  - bit-index constants for WB, SUPPLY, INV, RMISS, WMISS
  - address and data slice ranges
  - MSG_W=13
  - FSM state encoding
  - owner ID constants
- One sub-module, `rr_arbiter2`: 2-input round-robin pick with pointer update on a `grant_done` strobe. The rest is the top FSM.

## Test plan
- Reset: hold `reset` 2 cycles with both `req` high → all outputs 0; first grant goes to cpu1 2 cycles after `reset` falls.
- WB, `msg_cpu1`={WB, addr 3'b101, data 4'hA} → `memory_write`=1 at addr 5 with data A for exactly 1 cycle; `reply_valid_cpu1` 2 cycles after sampling; `snoop_valid_cpu2` pulses once.
- RMISS from cpu2 at addr 2, memory holds 4'h7, no supply → `reply_msg` data 7 at T+3 (MEM_LATENCY=1); repeat with MEM_LATENCY=3 → reply at T+5.
- RMISS from cpu1 at addr 4 while cpu2 drives SUPPLY addr 4 data 4'hC during MEM → reply data C. A SUPPLY for addr 6 instead → memory data returned.
- Both `req` held continuously → grants alternate cpu1, cpu2, cpu1, …; no CPU gets two consecutive grants.
- `reset` asserted during MEM → no `reply_valid`; state IDLE next cycle; a new request afterwards completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the snooping-bus arbiter.
// Contents: message width and field positions, FSM state encoding,
// owner IDs, transaction kinds and a kind decoder.
package bus_pkg;

    localparam int MSG_W  = 13;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 4;

    // Message bit positions
    localparam int WB_BIT     = 12;
    localparam int SUPPLY_BIT = 11;
    localparam int INV_BIT    = 10;
    localparam int RMISS_BIT  = 9;
    localparam int WMISS_BIT  = 8;
    localparam int RSVD_BIT   = 7;
    localparam int ADDR_HI    = 6;
    localparam int ADDR_LO    = 4;
    localparam int DATA_HI    = 3;
    localparam int DATA_LO    = 0;

    typedef logic [MSG_W-1:0] msg_t;

    // Kind bits echoed back in the reply (SUPPLY belongs to snoopers only)
    localparam msg_t KIND_MASK = (msg_t'(1) << WB_BIT)    | (msg_t'(1) << INV_BIT) |
                                 (msg_t'(1) << RMISS_BIT) | (msg_t'(1) << WMISS_BIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_MEM   = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWNER_CPU1 = 1'b0,
        OWNER_CPU2 = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        KIND_INV   = 2'd0,
        KIND_WB    = 2'd1,
        KIND_RMISS = 2'd2,
        KIND_WMISS = 2'd3
    } kind_e;

    // Anything other than exactly one recognised kind bit behaves as INV.
    function automatic kind_e decode_kind(input msg_t m);
        case ({m[WB_BIT], m[INV_BIT], m[RMISS_BIT], m[WMISS_BIT]})
            4'b1000: decode_kind = KIND_WB;
            4'b0010: decode_kind = KIND_RMISS;
            4'b0001: decode_kind = KIND_WMISS;
            default: decode_kind = KIND_INV;
        endcase
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Bundle of CPU-side and memory-side signals of the snooping bus.
// slave  : the arbiter (drives grants, snoops, replies, memory port, busy)
// master : the CPUs and the memory (drive requests, messages, read data)
interface snoop_bus_arbiter_if;
    import bus_pkg::*;

    logic                req_cpu1;
    logic                req_cpu2;
    msg_t                msg_cpu1;
    msg_t                msg_cpu2;
    logic                gnt_cpu1;
    logic                gnt_cpu2;
    logic                snoop_valid_cpu1;
    logic                snoop_valid_cpu2;
    msg_t                snoop_msg;
    logic                reply_valid_cpu1;
    logic                reply_valid_cpu2;
    msg_t                reply_msg;
    logic                memory_write;
    logic [ADDR_W-1:0]   memory_address;
    logic [DATA_W-1:0]   memory_data_in;
    logic [DATA_W-1:0]   memory_data_out;
    logic                busy;

    modport slave (
        input  req_cpu1, req_cpu2, msg_cpu1, msg_cpu2, memory_data_out,
        output gnt_cpu1, gnt_cpu2, snoop_valid_cpu1, snoop_valid_cpu2, snoop_msg,
               reply_valid_cpu1, reply_valid_cpu2, reply_msg,
               memory_write, memory_address, memory_data_in, busy
    );

    modport master (
        output req_cpu1, req_cpu2, msg_cpu1, msg_cpu2, memory_data_out,
        input  gnt_cpu1, gnt_cpu2, snoop_valid_cpu1, snoop_valid_cpu2, snoop_msg,
               reply_valid_cpu1, reply_valid_cpu2, reply_msg,
               memory_write, memory_address, memory_data_in, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker.
// Ports: clock, reset (sync, active-high); req[0]=cpu1, req[1]=cpu2;
// grant_done strobes when the transaction of done_owner completes, which
// hands priority to the other CPU; pick_valid/pick give the current choice.
module rr_arbiter2
    import bus_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_done,
    input  owner_e     done_owner,
    output logic       pick_valid,
    output owner_e     pick
);

    owner_e ptr_q;
    owner_e ptr_d;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick_valid = |req;
        pick       = ptr_q;
        if (req == 2'b01) begin
            pick = OWNER_CPU1;
        end else if (req == 2'b10) begin
            pick = OWNER_CPU2;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_done) begin
            ptr_d = (done_owner == OWNER_CPU1) ? OWNER_CPU2 : OWNER_CPU1;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignment for flops so all registers update together at the edge.
        if (reset) begin
            ptr_q <= OWNER_CPU1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Arbiter and sequencer for the shared snooping bus of two cache CPUs and
// one data memory. One transaction at a time: IDLE -> SNOOP -> (MEM) -> RESP.
// Ports: clock, reset (sync, active-high), bus (slave modport) carrying
// requests/messages, grants, snoop broadcast, replies, memory port and busy.
// Parameter MEM_LATENCY (1..7): cycles from memory address to read data.
module snoop_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    snoop_bus_arbiter_if.slave   bus
);

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY);

    state_e            state_q,     state_d;
    owner_e            owner_q,     owner_d;
    msg_t              msg_q,       msg_d;
    logic [2:0]        cnt_q,       cnt_d;
    logic              sup_valid_q, sup_valid_d;
    logic [DATA_W-1:0] sup_data_q,  sup_data_d;

    logic              pick_valid;
    owner_e            pick;
    kind_e             kind;
    msg_t              snooper_msg;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] reply_data;

    rr_arbiter2 u_rr (
        .clock      (clock),
        .reset      (reset),
        .req        ({bus.req_cpu2, bus.req_cpu1}),
        .grant_done (state_q == ST_RESP),
        .done_owner (owner_q),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    assign kind        = decode_kind(msg_q);
    assign addr_q      = msg_q[ADDR_HI:ADDR_LO];
    assign snooper_msg = (owner_q == OWNER_CPU1) ? bus.msg_cpu2 : bus.msg_cpu1;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        msg_d       = msg_q;
        cnt_d       = cnt_q;
        sup_valid_d = sup_valid_q;
        sup_data_d  = sup_data_q;

        case (state_q)
            ST_IDLE: begin
                sup_valid_d = 1'b0;
                if (pick_valid) begin
                    owner_d          = pick;
                    msg_d            = (pick == OWNER_CPU1) ? bus.msg_cpu1 : bus.msg_cpu2;
                    msg_d[RSVD_BIT]  = 1'b0;
                    state_d          = ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                if (kind == KIND_RMISS || kind == KIND_WMISS) begin
                    cnt_d   = LAT_LOAD;
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_MEM: begin
                // Last MEM cycle is the one that sees the counter at 1.
                if (cnt_q <= 3'd1) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // First matching SUPPLY from the snooper wins; later offers are ignored.
        if ((state_q == ST_SNOOP || state_q == ST_MEM) && !sup_valid_q &&
            snooper_msg[SUPPLY_BIT] && (snooper_msg[ADDR_HI:ADDR_LO] == addr_q)) begin
            sup_valid_d = 1'b1;
            sup_data_d  = snooper_msg[DATA_HI:DATA_LO];
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_CPU1;
            msg_q       <= '0;
            cnt_q       <= '0;
            sup_valid_q <= 1'b0;
            sup_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            msg_q       <= msg_d;
            cnt_q       <= cnt_d;
            sup_valid_q <= sup_valid_d;
            sup_data_q  <= sup_data_d;
        end
    end

    // Reply data: WB echoes, INV gives zero, misses prefer a snooper's line.
    always_comb begin
        case (kind)
            KIND_WB:                reply_data = msg_q[DATA_HI:DATA_LO];
            KIND_RMISS, KIND_WMISS: reply_data = sup_valid_q ? sup_data_q : bus.memory_data_out;
            default:                reply_data = '0;
        endcase
    end

    // Outputs, decoded from registered state only
    always_comb begin
        bus.gnt_cpu1         = 1'b0;
        bus.gnt_cpu2         = 1'b0;
        bus.snoop_valid_cpu1 = 1'b0;
        bus.snoop_valid_cpu2 = 1'b0;
        bus.reply_valid_cpu1 = 1'b0;
        bus.reply_valid_cpu2 = 1'b0;
        bus.reply_msg        = '0;
        bus.memory_write     = 1'b0;
        bus.memory_address   = '0;
        bus.memory_data_in   = '0;
        bus.snoop_msg        = msg_q;
        bus.busy             = (state_q != ST_IDLE);

        case (state_q)
            ST_SNOOP: begin
                bus.gnt_cpu1         = (owner_q == OWNER_CPU1);
                bus.gnt_cpu2         = (owner_q == OWNER_CPU2);
                bus.snoop_valid_cpu1 = (owner_q == OWNER_CPU2);
                bus.snoop_valid_cpu2 = (owner_q == OWNER_CPU1);
                bus.memory_address   = addr_q;
                if (kind == KIND_WB) begin
                    bus.memory_write   = 1'b1;
                    bus.memory_data_in = msg_q[DATA_HI:DATA_LO];
                end
            end
            ST_MEM: begin
                bus.memory_address = addr_q;
            end
            ST_RESP: begin
                bus.memory_address   = addr_q;
                bus.reply_valid_cpu1 = (owner_q == OWNER_CPU1);
                bus.reply_valid_cpu2 = (owner_q == OWNER_CPU2);
                bus.reply_msg        = msg_q & KIND_MASK;
                bus.reply_msg[ADDR_HI:ADDR_LO] = addr_q;
                bus.reply_msg[DATA_HI:DATA_LO] = reply_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: two instances (MEM_LATENCY 1 and 3),
// each with its own memory model. Stimulus pushes expected events (grant,
// snoop, memory write, reply) with their cycle numbers; a monitor per
// instance pops and compares whenever the DUT shows one of those events.
`timescale 1ns/1ps
module tb_snoop_bus_arbiter;
    import bus_pkg::*;

    localparam logic [4:0] K_NONE = 5'b00000;
    localparam logic [4:0] K_WB   = 5'b10000;
    localparam logic [4:0] K_SUP  = 5'b01000;
    localparam logic [4:0] K_INV  = 5'b00100;
    localparam logic [4:0] K_RM   = 5'b00010;
    localparam logic [4:0] K_WM   = 5'b00001;

    typedef enum logic [1:0] {EV_GNT, EV_SNOOP, EV_MEMW, EV_REPLY} ev_kind_e;
    typedef struct packed {
        ev_kind_e kind;
        logic     cpu;   // 0 = cpu1, 1 = cpu2
        msg_t     msg;
        int       cyc;
    } ev_t;

    logic clock = 1'b0;
    logic reset1;
    logic reset3;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  q1[$];
    ev_t  q3[$];
    logic [3:0] mem1 [8];
    logic [3:0] mem3 [8];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    snoop_bus_arbiter_if bus1 ();
    snoop_bus_arbiter_if bus3 ();

    snoop_bus_arbiter #(.MEM_LATENCY(1)) dut1 (.clock(clock), .reset(reset1), .bus(bus1));
    snoop_bus_arbiter #(.MEM_LATENCY(3)) dut3 (.clock(clock), .reset(reset3), .bus(bus3));

    function automatic logic [3:0] mem_init(input int i);
        case (i)
            0:       return 4'hE;
            2:       return 4'h7;
            4:       return 4'h3;
            default: return 4'(i);
        endcase
    endfunction

    // Memory models: combinational read, write on the clock edge.
    assign bus1.memory_data_out = mem1[bus1.memory_address];
    assign bus3.memory_data_out = mem3[bus3.memory_address];

    always @(posedge clock) begin
        if (reset1) for (int i = 0; i < 8; i++) mem1[i] <= mem_init(i);
        else if (bus1.memory_write) mem1[bus1.memory_address] <= bus1.memory_data_in;
    end

    always @(posedge clock) begin
        if (reset3) for (int i = 0; i < 8; i++) mem3[i] <= mem_init(i);
        else if (bus3.memory_write) mem3[bus3.memory_address] <= bus3.memory_data_in;
    end

    function automatic msg_t mk(input logic [4:0] k, input logic [2:0] a, input logic [3:0] d);
        return {k, 1'b0, a, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int d, input ev_kind_e k, input logic cpu, input msg_t m, input int c);
        ev_t e;
        e = '{kind: k, cpu: cpu, msg: m, cyc: c};
        if (d == 1) q1.push_back(e);
        else        q3.push_back(e);
    endtask

    task automatic observe(input int d, input ev_kind_e k, input logic cpu, input msg_t m);
        ev_t e;
        int  sz;
        sz = (d == 1) ? q1.size() : q3.size();
        if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d %s cpu%0d at cycle %0d: got unexpected event msg %0h, expected none",
                     d, k.name(), 32'(cpu) + 1, cyc, m);
        end else begin
            if (d == 1) e = q1.pop_front();
            else        e = q3.pop_front();
            check($sformatf("dut%0d %s cpu%0d kind/cpu/msg", d, k.name(), 32'(cpu) + 1),
                  32'({k, cpu, m}), 32'({e.kind, e.cpu, e.msg}));
            check($sformatf("dut%0d %s cpu%0d cycle", d, k.name(), 32'(cpu) + 1), cyc, e.cyc);
        end
    endtask

    // Monitors: sample on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (bus1.gnt_cpu1)         observe(1, EV_GNT,   1'b0, '0);
            if (bus1.gnt_cpu2)         observe(1, EV_GNT,   1'b1, '0);
            if (bus1.snoop_valid_cpu1) observe(1, EV_SNOOP, 1'b0, bus1.snoop_msg);
            if (bus1.snoop_valid_cpu2) observe(1, EV_SNOOP, 1'b1, bus1.snoop_msg);
            if (bus1.memory_write)     observe(1, EV_MEMW,  1'b0, msg_t'({bus1.memory_address, bus1.memory_data_in}));
            if (bus1.reply_valid_cpu1) observe(1, EV_REPLY, 1'b0, bus1.reply_msg);
            if (bus1.reply_valid_cpu2) observe(1, EV_REPLY, 1'b1, bus1.reply_msg);
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (bus3.gnt_cpu1)         observe(3, EV_GNT,   1'b0, '0);
            if (bus3.gnt_cpu2)         observe(3, EV_GNT,   1'b1, '0);
            if (bus3.snoop_valid_cpu1) observe(3, EV_SNOOP, 1'b0, bus3.snoop_msg);
            if (bus3.snoop_valid_cpu2) observe(3, EV_SNOOP, 1'b1, bus3.snoop_msg);
            if (bus3.memory_write)     observe(3, EV_MEMW,  1'b0, msg_t'({bus3.memory_address, bus3.memory_data_in}));
            if (bus3.reply_valid_cpu1) observe(3, EV_REPLY, 1'b0, bus3.reply_msg);
            if (bus3.reply_valid_cpu2) observe(3, EV_REPLY, 1'b1, bus3.reply_msg);
        end
    end

    task automatic set_req(input int d, input logic cpu, input logic r, input msg_t m);
        if (d == 1) begin
            if (!cpu) begin bus1.req_cpu1 = r; bus1.msg_cpu1 = m; end
            else      begin bus1.req_cpu2 = r; bus1.msg_cpu2 = m; end
        end else begin
            if (!cpu) begin bus3.req_cpu1 = r; bus3.msg_cpu1 = m; end
            else      begin bus3.req_cpu2 = r; bus3.msg_cpu2 = m; end
        end
    endtask

    // Issue one request while the DUT is idle and hold it until the reply.
    // lat = extra MEM cycles (0 for WB/INV). Returns in the IDLE cycle after the reply.
    task automatic run_txn(input int d, input logic cpu, input msg_t m, input int lat, input msg_t reply);
        int t;
        int tr;
        t  = cyc;
        tr = t + 2 + lat;
        push_ev(d, EV_GNT,   cpu,  '0, t + 1);
        push_ev(d, EV_SNOOP, ~cpu, m,  t + 1);
        if (m[WB_BIT]) push_ev(d, EV_MEMW, 1'b0, msg_t'(m[6:0]), t + 1);
        push_ev(d, EV_REPLY, cpu, reply, tr);
        set_req(d, cpu, 1'b1, m);
        repeat (tr + 1 - t) @(posedge clock);
        #1;
        set_req(d, cpu, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 ns, expected finish");
        $fatal(1);
    end

    initial begin
        int   p;
        int   t;
        msg_t m1;
        msg_t m2;
        msg_t m;

        m1 = mk(K_INV, 3'd1, 4'h9);
        m2 = mk(K_INV, 3'd2, 4'h4);
        reset1 = 1'b1;
        reset3 = 1'b1;
        bus1.req_cpu1 = 1'b1; bus1.msg_cpu1 = m1;
        bus1.req_cpu2 = 1'b1; bus1.msg_cpu2 = m2;
        bus3.req_cpu1 = 1'b0; bus3.msg_cpu1 = '0;
        bus3.req_cpu2 = 1'b0; bus3.msg_cpu2 = '0;

        // Reset held two cycles with both requests high: everything quiet.
        repeat (2) @(posedge clock);
        #1;
        check("reset dut1 control outputs",
              {bus1.gnt_cpu1, bus1.gnt_cpu2, bus1.snoop_valid_cpu1, bus1.snoop_valid_cpu2,
               bus1.reply_valid_cpu1, bus1.reply_valid_cpu2, bus1.memory_write, bus1.busy}, 0);
        check("reset dut1 snoop_msg", bus1.snoop_msg, 0);
        check("reset dut1 reply_msg", bus1.reply_msg, 0);
        check("reset dut1 memory addr/data", {bus1.memory_address, bus1.memory_data_in}, 0);
        check("reset dut3 busy", bus3.busy, 0);

        // Both held continuously: cpu1 first, then strict alternation, one
        // INV transaction every 3 cycles (SNOOP, RESP, IDLE).
        p = cyc;
        for (int k = 0; k < 4; k++) begin
            m = (k % 2 == 0) ? m1 : m2;
            push_ev(1, EV_GNT,   1'(k % 2),       '0, p + 1 + 3 * k);
            push_ev(1, EV_SNOOP, 1'((k + 1) % 2), m,  p + 1 + 3 * k);
            push_ev(1, EV_REPLY, 1'(k % 2), mk(K_INV, m[6:4], 4'h0), p + 2 + 3 * k);
        end
        reset1 = 1'b0;
        reset3 = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        set_req(1, 1'b0, 1'b0, '0);
        set_req(1, 1'b1, 1'b0, '0);

        // WB from cpu1: write addr 5 data A, reply at T+2.
        run_txn(1, 1'b0, mk(K_WB, 3'd5, 4'hA), 0, mk(K_WB, 3'd5, 4'hA));
        // RMISS from cpu2, no supply, latency 1: memory data 7 at T+3.
        run_txn(1, 1'b1, mk(K_RM, 3'd2, 4'h0), 1, mk(K_RM, 3'd2, 4'h7));
        // Same on the latency-3 instance: reply at T+5.
        run_txn(3, 1'b1, mk(K_RM, 3'd2, 4'h0), 3, mk(K_RM, 3'd2, 4'h7));
        // Read back the line written by the WB above.
        run_txn(1, 1'b1, mk(K_RM, 3'd5, 4'h0), 1, mk(K_RM, 3'd5, 4'hA));

        // Snooper cpu2 supplies addr 4 data C: supplied data beats memory (3).
        bus1.msg_cpu2 = mk(K_SUP, 3'd4, 4'hC);
        run_txn(1, 1'b0, mk(K_RM, 3'd4, 4'h0), 1, mk(K_RM, 3'd4, 4'hC));
        // Supply for a different address is ignored: memory data 3.
        bus1.msg_cpu2 = mk(K_SUP, 3'd6, 4'hC);
        run_txn(1, 1'b0, mk(K_RM, 3'd4, 4'h0), 1, mk(K_RM, 3'd4, 4'h3));
        bus1.msg_cpu2 = '0;

        // First capture wins: C offered in SNOOP, 5 offered during MEM.
        bus3.msg_cpu2 = mk(K_SUP, 3'd4, 4'hC);
        fork
            run_txn(3, 1'b0, mk(K_RM, 3'd4, 4'h0), 3, mk(K_RM, 3'd4, 4'hC));
            begin
                repeat (2) @(posedge clock);
                #1;
                bus3.msg_cpu2 = mk(K_SUP, 3'd4, 4'h5);
            end
        join
        bus3.msg_cpu2 = '0;

        // WMISS from cpu2 at addr 0: memory data E.
        run_txn(1, 1'b1, mk(K_WM, 3'd0, 4'h0), 1, mk(K_WM, 3'd0, 4'hE));
        // INV carries data F but replies with data 0.
        run_txn(1, 1'b1, mk(K_INV, 3'd7, 4'hF), 0, mk(K_INV, 3'd7, 4'h0));
        // No kind bits: behaves as INV, kind bits echoed as zero.
        run_txn(1, 1'b0, mk(K_NONE, 3'd3, 4'h6), 0, mk(K_NONE, 3'd3, 4'h0));

        // Reset during MEM on the latency-3 instance: no reply, IDLE next cycle.
        t = cyc;
        m = mk(K_RM, 3'd2, 4'h0);
        push_ev(3, EV_GNT,   1'b0, '0, t + 1);
        push_ev(3, EV_SNOOP, 1'b1, m,  t + 1);
        set_req(3, 1'b0, 1'b1, m);
        repeat (2) @(posedge clock);
        #1;
        reset3 = 1'b1;
        @(posedge clock);
        #1;
        check("dut3 busy after mid-MEM reset", bus3.busy, 0);
        check("dut3 replies after mid-MEM reset", {bus3.reply_valid_cpu1, bus3.reply_valid_cpu2}, 0);
        set_req(3, 1'b0, 1'b0, '0);
        reset3 = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("dut3 pending events after abandoned txn", q3.size(), 0);
        // A fresh request then completes normally.
        run_txn(3, 1'b0, mk(K_RM, 3'd2, 4'h0), 3, mk(K_RM, 3'd2, 4'h7));

        repeat (4) @(posedge clock);
        #1;
        check("dut1 pending expected events", q1.size(), 0);
        check("dut3 pending expected events", q3.size(), 0);
        check("final busy", {bus1.busy, bus3.busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
